// File: rtl/flash_rd_ctrl_if.sv
// Cart read bus between the Z80 memory decoder and the flash read engine.
// Latency: none, wires only.
// Backpressure: wait_n low stalls the requester's bus cycle.
interface flash_rd_ctrl_if #(
    parameter int ADDR_W = 22
);
    logic              rd_req;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        rd_data;
    logic              wait_n;

    modport master (output rd_req, output addr, input  rd_data, input  wait_n);
    modport slave  (input  rd_req, input  addr, output rd_data, output wait_n);
endinterface

// File: rtl/flash_rd_ctrl.sv
// Flash read engine with a one-entry last-address cache; optional next-address prefetch (FLASH_PREFETCH_EN).
// Latency: miss holds wait_n low ACCESS_CYCLES+1 clks; hit is zero-wait.
// Backpressure: stretches the Z80 bus cycle with wait_n; one read per rd_req strobe.
module flash_rd_ctrl #(
    parameter int ADDR_W        = 22,
    parameter int ACCESS_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    flash_rd_ctrl_if.slave      bus,
    output logic [ADDR_W-1:0]   FL_ADDR,
    input  logic [7:0]          FL_DQ,
    output logic                FL_CE_N,
    output logic                FL_OE_N,
    output logic                FL_WE_N,
    output logic                FL_RST_N
);

`ifdef FLASH_PREFETCH_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2, PREFETCH = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] tag_q;
    logic              valid_q;
    logic [7:0]        data_q;
    logic [ADDR_W-1:0] fl_addr_q;
    logic              fl_en_n_q;

    logic              cnt_zero;
    logic              main_hit;
    logic              hit;
    logic              stall;
    logic              start_miss;
    logic              fill;
    logic              count;

`ifdef FLASH_PREFETCH_EN
    logic [ADDR_W-1:0] pf_tag_q;
    logic [7:0]        pf_data_q;
    logic              pf_valid_q;
    logic              last_fill_q;
    logic              pf_hit;
    logic              promote;
    logic              start_pf;
    logic              pf_fill;

    assign pf_hit = pf_valid_q && (bus.addr == pf_tag_q);
    assign hit    = main_hit || pf_hit;
    // A prefetch-entry hit must present its byte in the same cycle to stay zero-wait.
    assign bus.rd_data = promote ? pf_data_q : data_q;
`else
    assign hit         = main_hit;
    assign bus.rd_data = data_q;
`endif

    assign cnt_zero = (cnt_q == '0);
    assign main_hit = valid_q && (bus.addr == tag_q);

    // Reset must release the Z80 immediately, even if rd_req is still high.
    assign bus.wait_n = !(stall && rst_n);

    assign FL_ADDR  = fl_addr_q;
    assign FL_CE_N  = fl_en_n_q;
    assign FL_OE_N  = fl_en_n_q;
    assign FL_WE_N  = 1'b1;
    assign FL_RST_N = rst_n;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, bus stall and datapath strobes.
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        start_miss = 1'b0;
        fill       = 1'b0;
        count      = 1'b0;
`ifdef FLASH_PREFETCH_EN
        promote    = 1'b0;
        start_pf   = 1'b0;
        pf_fill    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.rd_req) begin
                    if (hit) begin
                        state_d = DONE;
`ifdef FLASH_PREFETCH_EN
                        promote = !main_hit;
`endif
                    end else begin
                        state_d    = ACCESS;
                        stall      = 1'b1;
                        start_miss = 1'b1;
                    end
                end
            end
            ACCESS: begin
                stall = 1'b1;
                count = !cnt_zero;
                if (cnt_zero) begin
                    fill    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.rd_req) begin
`ifdef FLASH_PREFETCH_EN
                    if (last_fill_q) begin
                        state_d  = PREFETCH;
                        start_pf = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef FLASH_PREFETCH_EN
            PREFETCH: begin
                stall = bus.rd_req;
                count = !cnt_zero;
                if (cnt_zero) begin
                    pf_fill = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Flash pin timing, access counter and cache entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            tag_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            fl_addr_q <= '0;
            fl_en_n_q <= 1'b1;
`ifdef FLASH_PREFETCH_EN
            pf_tag_q    <= '0;
            pf_data_q   <= '0;
            pf_valid_q  <= 1'b0;
            last_fill_q <= 1'b0;
`endif
        end else begin
            if (start_miss) begin
                fl_addr_q <= bus.addr;
                tag_q     <= bus.addr;
                fl_en_n_q <= 1'b0;
                cnt_q     <= CNT_W'(ACCESS_CYCLES - 1);
`ifdef FLASH_PREFETCH_EN
                pf_valid_q <= 1'b0;
`endif
            end else if (count) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (fill) begin
                data_q    <= FL_DQ;
                valid_q   <= 1'b1;
                fl_en_n_q <= 1'b1;
            end
`ifdef FLASH_PREFETCH_EN
            if (fill)
                last_fill_q <= 1'b1;
            else if (state_q == DONE && !bus.rd_req)
                last_fill_q <= 1'b0;
            if (start_pf) begin
                fl_addr_q <= tag_q + ADDR_W'(1);
                pf_tag_q  <= tag_q + ADDR_W'(1);
                fl_en_n_q <= 1'b0;
                cnt_q     <= CNT_W'(ACCESS_CYCLES - 1);
            end
            if (pf_fill) begin
                pf_data_q  <= FL_DQ;
                pf_valid_q <= 1'b1;
                fl_en_n_q  <= 1'b1;
            end
            if (promote) begin
                tag_q      <= pf_tag_q;
                data_q     <= pf_data_q;
                pf_valid_q <= 1'b0;
            end
`endif
        end
    end

endmodule
